// File: rtl/fb_sram_arbiter.sv
// Single-port SRAM arbiter for the RGB332 framebuffer: scan-out reads win, buffered CPU writes
// and the optional hardware fill (built when FB_FILL_EN is defined) use the free cycles.
module fb_sram_arbiter #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FB_SIZE = 76800
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [16:0]             wr_addr,
    input  logic [7:0]              wr_data,
    output logic [$clog2(DEPTH):0]  level,
    input  logic                    scan_req,
    input  logic [16:0]             scan_addr,
    output logic [7:0]              pix_data,
    output logic                    pix_valid,
    output logic [16:0]             sram_a,
    output logic [7:0]              sram_dout,
    output logic                    sram_dout_en,
    output logic                    sram_n_we,
    input  logic [7:0]              sram_din,
    input  logic                    fill_start,
    input  logic [7:0]              fill_color,
    output logic                    fill_busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    typedef enum logic [1:0] {SlotIdle, SlotRead, SlotFill, SlotWrite} slot_e;

    slot_e       slot;
    logic [24:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [24:0] head;
    logic        full, empty, push, pop;
    logic        read_slot_q;
    logic [16:0] fill_addr;
    logic [7:0]  fill_byte;

    // Write FIFO: pointers carry one extra bit so full and empty are distinguishable.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = (slot == SlotWrite);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        slot = SlotIdle;
        if (scan_req)       slot = SlotRead;
        else if (fill_busy) slot = SlotFill;
        else if (!empty)    slot = SlotWrite;
    end

`ifdef FB_FILL_EN
    typedef enum logic {FillIdle, FillRun} fill_state_e;

    localparam logic [16:0] FB_LAST = 17'(FB_SIZE - 1);

    fill_state_e fill_state_q;
    logic [16:0] fill_cnt_q;
    logic [7:0]  fill_color_q;

    // Counter only moves on granted FILL slots, so interleaved reads stretch the fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_state_q <= FillIdle;
            fill_cnt_q   <= '0;
            fill_color_q <= '0;
        end else begin
            unique case (fill_state_q)
                FillIdle: begin
                    if (fill_start) begin
                        fill_color_q <= fill_color;
                        fill_cnt_q   <= '0;
                        fill_state_q <= FillRun;
                    end
                end
                FillRun: begin
                    if (slot == SlotFill) begin
                        if (fill_cnt_q == FB_LAST) fill_state_q <= FillIdle;
                        else                       fill_cnt_q   <= fill_cnt_q + 1'b1;
                    end
                end
                default: fill_state_q <= FillIdle;
            endcase
        end
    end

    assign fill_busy = (fill_state_q == FillRun);
    assign fill_addr = fill_cnt_q;
    assign fill_byte = fill_color_q;
`else
    localparam int unsigned UNUSED_FB_SIZE = FB_SIZE;
    logic unused_fill;

    assign unused_fill = ^{fill_start, fill_color};
    assign fill_busy   = 1'b0;
    assign fill_addr   = '0;
    assign fill_byte   = '0;
`endif

    // Pins are registered from this cycle's decision; read data is captured one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_a       <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            sram_n_we    <= 1'b1;
            read_slot_q  <= 1'b0;
            pix_data     <= '0;
            pix_valid    <= 1'b0;
        end else begin
            pix_valid   <= read_slot_q;
            if (read_slot_q) pix_data <= sram_din;
            read_slot_q <= (slot == SlotRead);
            unique case (slot)
                SlotRead: begin
                    sram_a       <= scan_addr;
                    sram_n_we    <= 1'b1;
                    sram_dout_en <= 1'b0;
                end
                SlotFill: begin
                    sram_a       <= fill_addr;
                    sram_dout    <= fill_byte;
                    sram_n_we    <= 1'b0;
                    sram_dout_en <= 1'b1;
                end
                SlotWrite: begin
                    sram_a       <= head[24:8];
                    sram_dout    <= head[7:0];
                    sram_n_we    <= 1'b0;
                    sram_dout_en <= 1'b1;
                end
                default: begin
                    sram_n_we    <= 1'b1;
                    sram_dout_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter; the fill scenario is built only when FB_FILL_EN is defined.
module tb_fb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [3:0]  level;
    logic        scan_req = 1'b0;
    logic [16:0] scan_addr = '0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [16:0] sram_a;
    logic [7:0]  sram_dout;
    logic        sram_dout_en;
    logic        sram_n_we;
    logic [7:0]  sram_din = '0;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_color = '0;
    logic        fill_busy;

    int checks = 0;
    int errors = 0;

    logic [24:0] exp_q [$];
    logic [24:0] e;

    fb_sram_arbiter #(
        .DEPTH   (8),
        .FB_SIZE (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .level        (level),
        .scan_req     (scan_req),
        .scan_addr    (scan_addr),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .sram_a       (sram_a),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_n_we    (sram_n_we),
        .sram_din     (sram_din),
        .fill_start   (fill_start),
        .fill_color   (fill_color),
        .fill_busy    (fill_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a"},     32'(sram_a), 32'h0);
        check({tag, "_dout"},  32'(sram_dout), 32'h0);
        check({tag, "_en"},    32'(sram_dout_en), 32'h0);
        check({tag, "_nwe"},   32'(sram_n_we), 32'h1);
        check({tag, "_pix"},   32'(pix_data), 32'h0);
        check({tag, "_pixv"},  32'(pix_valid), 32'h0);
        check({tag, "_level"}, 32'(level), 32'h0);
        check({tag, "_ready"}, 32'(wr_ready), 32'h1);
        check({tag, "_busy"},  32'(fill_busy), 32'h0);
    endtask

    task automatic check_write(input string tag, input logic [16:0] a, input logic [7:0] d);
        check({tag, "_a"},    32'(sram_a), 32'(a));
        check({tag, "_dout"}, 32'(sram_dout), 32'(d));
        check({tag, "_nwe"},  32'(sram_n_we), 32'h0);
        check({tag, "_en"},   32'(sram_dout_en), 32'h1);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        // Single write on an idle bus
        wr_valid = 1'b1; wr_addr = 17'h12345; wr_data = 8'hA5;
        @(negedge clk);
        check("single_level1", 32'(level), 32'h1);
        check("single_nwe_early", 32'(sram_n_we), 32'h1);
        wr_valid = 1'b0;
        @(negedge clk);
        check_write("single", 17'h12345, 8'hA5);
        check("single_level0", 32'(level), 32'h0);
        @(negedge clk);
        check("single_nwe_after", 32'(sram_n_we), 32'h1);
        check("single_en_after", 32'(sram_dout_en), 32'h0);
        check("single_a_hold", 32'(sram_a), 32'h12345);

        // Read priority over two queued writes
        scan_req = 1'b1; scan_addr = 17'h00100;
        wr_valid = 1'b1; wr_addr = 17'h00AAA; wr_data = 8'h11;
        @(negedge clk);
        check("prio_read_a", 32'(sram_a), 32'h00100);
        check("prio_read_nwe", 32'(sram_n_we), 32'h1);
        check("prio_pixv_early", 32'(pix_valid), 32'h0);
        wr_addr = 17'h00BBB; wr_data = 8'h22; sram_din = 8'h3C;
        @(negedge clk);
        check("prio_level2", 32'(level), 32'h2);
        check("prio_pixv", 32'(pix_valid), 32'h1);
        check("prio_pix", 32'(pix_data), 32'h3C);
        wr_valid = 1'b0; scan_req = 1'b0; sram_din = 8'h5A;
        @(negedge clk);
        check_write("prio_w0", 17'h00AAA, 8'h11);
        check("prio_pix2", 32'(pix_data), 32'h5A);
        @(negedge clk);
        check_write("prio_w1", 17'h00BBB, 8'h22);
        check("prio_pixv_end", 32'(pix_valid), 32'h0);
        @(negedge clk);
        check("prio_idle_nwe", 32'(sram_n_we), 32'h1);
        check("prio_level0", 32'(level), 32'h0);

        // Full / backpressure: scan-out holds the bus while 9 pushes are offered
        scan_req = 1'b1; scan_addr = 17'h0FFFF;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = 17'h00100 + 17'(i); wr_data = 8'h80 + 8'(i);
            @(negedge clk);
        end
        check("full_level8", 32'(level), 32'h8);
        check("full_ready0", 32'(wr_ready), 32'h0);
        wr_addr = 17'h00108; wr_data = 8'h88;
        @(negedge clk);
        check("full_held_level", 32'(level), 32'h8);
        check("full_held_nwe", 32'(sram_n_we), 32'h1);
        scan_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check_write($sformatf("drain%0d", k), 17'h00100 + 17'(k), 8'h80 + 8'(k));
            if (k == 0) check("drain_ready", 32'(wr_ready), 32'h1);
            if (k == 1) wr_valid = 1'b0;
        end
        @(negedge clk);
        check("drain_idle_nwe", 32'(sram_n_we), 32'h1);
        check("drain_level0", 32'(level), 32'h0);

        // Interleave: writes only in gaps between alternate scan claims
        scan_req = 1'b1; scan_addr = 17'h1F000;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = 17'h02000 + 17'(i); wr_data = 8'hC0 + 8'(i);
            exp_q.push_back({wr_addr, wr_data});
            @(negedge clk);
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            scan_req = (k % 2 == 1); scan_addr = 17'h1F000 + 17'(k);
            @(negedge clk);
            if (scan_req) begin
                check($sformatf("il%0d_read_nwe", k), 32'(sram_n_we), 32'h1);
                check($sformatf("il%0d_read_a", k), 32'(sram_a), 32'(scan_addr));
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_write($sformatf("il%0d_w", k), e[24:8], e[7:0]);
            end else begin
                check($sformatf("il%0d_idle_nwe", k), 32'(sram_n_we), 32'h1);
            end
        end
        scan_req = 1'b0;
        @(negedge clk);

`ifdef FB_FILL_EN
        // Fill 16 bytes with one push queued behind it and a restart attempt mid-fill
        fill_start = 1'b1; fill_color = 8'hE0;
        @(negedge clk);
        fill_start = 1'b0; fill_color = 8'h00;
        check("fill_busy_rise", 32'(fill_busy), 32'h1);
        wr_valid = 1'b1; wr_addr = 17'h1ABCD; wr_data = 8'h77;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            check_write($sformatf("fill%0d", a), 17'(a), 8'hE0);
            check($sformatf("fill%0d_busy", a), 32'(fill_busy), (a == 15) ? 32'h0 : 32'h1);
            if (a == 0) begin
                wr_valid = 1'b0;
                check("fill_level1", 32'(level), 32'h1);
            end
            if (a == 5) begin
                fill_start = 1'b1; fill_color = 8'h1F;
            end
            if (a == 6) fill_start = 1'b0;
        end
        @(negedge clk);
        check_write("fill_queued", 17'h1ABCD, 8'h77);
        @(negedge clk);
        check("fill_end_level", 32'(level), 32'h0);
        check("fill_end_busy", 32'(fill_busy), 32'h0);
`endif

        // Reset mid-operation with 3 queued entries (and a running fill when built)
        scan_req = 1'b1; scan_addr = 17'h00777; sram_din = 8'h6B;
`ifdef FB_FILL_EN
        fill_start = 1'b1; fill_color = 8'h3A;
`endif
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 17'h03000 + 17'(i); wr_data = 8'h50 + 8'(i);
            @(negedge clk);
            fill_start = 1'b0;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("prerst_level3", 32'(level), 32'h3);
        check("prerst_pix", 32'(pix_data), 32'h6B);
`ifdef FB_FILL_EN
        check("prerst_busy", 32'(fill_busy), 32'h1);
`endif
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0; scan_req = 1'b0;
        @(negedge clk);
        check("postrst_nwe", 32'(sram_n_we), 32'h1);
        check("postrst_level", 32'(level), 32'h0);
        wr_valid = 1'b1; wr_addr = 17'h00042; wr_data = 8'h99;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        check_write("postrst_w", 17'h00042, 8'h99);
        @(negedge clk);
        check("postrst_idle_nwe", 32'(sram_n_we), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
